gamma_maxq_pipe: RTL
====================

Name: gamma_maxq_pipe

Overview:
- Parametrised successor of the discount-factor stage in the parallel Q-learning datapath.
- Selects the max-Q value of the next state from NUM_STATES per-state candidates and multiplies it by gamma in signed fixed point.
- Two-stage registered pipeline with valid/ready handshake on both sides.
- Output (gamma*maxQ) feeds all EN update blocks.

Parameters:
- NUM_STATES, 6, number of per-state max-Q inputs.
- DATA_W, 24, width of Q, gamma and result (signed two's complement).
- FRAC_W, 14, fractional bits of the fixed-point format (1.0 = 2^FRAC_W).
- SEL_W, $clog2(NUM_STATES), state-select width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  pipeline can accept a request.
- s_to_en  in  SEL_W  next-state index.
- max_q_bus  in  NUM_STATES*DATA_W  per-state max-Q; state k occupies bits [k*DATA_W +: DATA_W].
- gamma  in  DATA_W  discount factor, sampled with the request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- gamma_maxq  out  DATA_W  saturated product.
- sel_err  out  1  sticky: an out-of-range s_to_en was accepted.
- sat_flag  out  1  sticky: a result saturated.

Behaviour:
- Reset (asynchronous, immediate):
  - s1_valid, out_valid, sel_err and sat_flag clear to 0.
  - gamma_maxq and the stage-1 data registers clear to 0.
  - An in-flight transaction is discarded.
  - in_ready is 1 after reset.
- Handshake:
  - Transfer on in_valid&&in_ready, or on out_valid&&out_ready.
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready by design.
- Stage 1, on accept: register max_q_bus[s_to_en] and gamma, and set s1_valid.
  - If s_to_en >= NUM_STATES, select state 0 and set sel_err.
  - s1_valid clears when s2_load occurs without a new accept.
- Stage 2, on s2_load:
  - p = signed(q)*signed(gamma), 2*DATA_W bits.
  - r = p >>> FRAC_W (arithmetic shift, truncation toward -inf).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. On clamp, set sat_flag.
  - Register r into gamma_maxq and set out_valid.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Backpressure:
  - While out_valid && !out_ready, gamma_maxq and out_valid hold stable.
  - Stage 1 holds one more item, then in_ready drops.
  - No item is lost or duplicated.
- Simultaneous output handshake and s2_load: gamma_maxq updates to the new value and out_valid stays 1.
- Output handshake with no s2_load: out_valid clears and gamma_maxq keeps its last value.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: GAMMA_MAXQ_ROUND_EN.
- Defined: before the shift, add 2^(FRAC_W-1) to p, giving round-half-up (toward +inf). Saturation follows the rounding.
- Undefined: truncation as described above. Latency is 2 cycles in both cases.

Decomposition:
- Shared package gamma_maxq_pkg holds:
  - the DATA_W and FRAC_W defaults;
  - the ONE_FX constant (2^FRAC_W);
  - the FX_MAX and FX_MIN saturation constants;
  - a fixed-point typedef.
- One sub-module, fx_mul_sat: combinational signed multiply, optional rounding, shift and saturation, with a sat indication output.
- Select and pipeline control stay in the top module.

Test Plan:
- Q3=0x008000 (2.0), gamma=0x00399A (~0.9), s_to_en=3, out_ready=1 -> gamma_maxq=0x007334 (29492) with out_valid 2 cycles after accept; sel_err=0.
- Q1=0xFFC000 (-1.0), gamma=0x002000 (0.5), s_to_en=1 -> gamma_maxq=0xFFE000; negative arithmetic is correct.
- Q0=0x7FFFFF, gamma=0x7FFFFF -> gamma_maxq=0x7FFFFF and sat_flag=1; a following Q0=0x800000, gamma=0x7FFFFF -> 0x800000.
- s_to_en=7, Q0=0x004000, gamma=0x004000 -> result 0x004000 (state 0 used) and sel_err=1 until reset.
- Rounding: Q=0x002000, gamma=0x000001 -> 0x000000 without GAMMA_MAXQ_ROUND_EN; 0x000001 with it.
- Backpressure and reset:
  - Issue 4 back-to-back requests, out_ready=0 for 3 cycles -> in_ready drops after 2 accepts and the output is held stable; results then emerge in order with no loss.
  - Assert RST mid-stream -> out_valid=0 immediately and flags cleared.

Source files
------------

// File: rtl/gamma_maxq_pkg.sv
// Shared fixed-point defaults and constants for the gamma*maxQ datapath.
package gamma_maxq_pkg;
  localparam int DATA_W_DEF = 24;
  localparam int FRAC_W_DEF = 14;

  typedef logic signed [DATA_W_DEF-1:0] fx_t;

  localparam fx_t ONE_FX = fx_t'(1) << FRAC_W_DEF;
  localparam fx_t FX_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam fx_t FX_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};
endpackage

// File: rtl/gamma_maxq_pipe_if.sv
// Request/response bundle of the gamma*maxQ stage; slave is the pipeline side.
interface gamma_maxq_pipe_if
  import gamma_maxq_pkg::*;
#(
  parameter int NUM_STATES = 6,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SEL_W      = $clog2(NUM_STATES)
);
  logic                         in_valid;
  logic                         in_ready;
  logic [SEL_W-1:0]             s_to_en;
  logic [NUM_STATES*DATA_W-1:0] max_q_bus;
  logic [DATA_W-1:0]            gamma;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            gamma_maxq;
  logic                         sel_err;
  logic                         sat_flag;

  modport master (
    output in_valid, s_to_en, max_q_bus, gamma, out_ready,
    input  in_ready, out_valid, gamma_maxq, sel_err, sat_flag
  );
  modport slave (
    input  in_valid, s_to_en, max_q_bus, gamma, out_ready,
    output in_ready, out_valid, gamma_maxq, sel_err, sat_flag
  );
endinterface

// File: rtl/gamma_maxq_pipe_fx_mul_sat.sv
// Combinational signed fixed-point multiply, shift and saturate.
// GAMMA_MAXQ_ROUND_EN selects round-half-up instead of truncation.
module fx_mul_sat
  import gamma_maxq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);
  localparam int PW = 2*DATA_W;
  localparam logic signed [PW-1:0] R_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] R_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0] p, pa, r;

  always_comb begin
    p = a * b;
`ifdef GAMMA_MAXQ_ROUND_EN
    // The full-width product has headroom, so adding half an LSB cannot wrap.
    pa = p + {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`else
    pa = p;
`endif
    r   = pa >>> FRAC_W;
    sat = 1'b0;
    y   = r[DATA_W-1:0];
    if (r > R_MAX) begin
      sat = 1'b1;
      y   = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (r < R_MIN) begin
      sat = 1'b1;
      y   = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
endmodule

// File: rtl/gamma_maxq_pipe.sv
// Two-stage gamma*maxQ pipeline: select next-state maxQ, then scale by gamma.
// Rounding mode is chosen in fx_mul_sat via GAMMA_MAXQ_ROUND_EN.
module gamma_maxq_pipe
  import gamma_maxq_pkg::*;
#(
  parameter int NUM_STATES = 6,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int SEL_W      = $clog2(NUM_STATES)
) (
  input logic             CLK,
  input logic             RST,
  gamma_maxq_pipe_if.slave bus
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_STATES-1);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_q_q, s1_q_d, s1_g_q, s1_g_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] gamma_maxq_q, gamma_maxq_d;
  logic              sel_err_q, sel_err_d, sat_flag_q, sat_flag_d;

  logic              accept, s2_load, oob;
  logic [SEL_W-1:0]  sel_idx;
  logic [DATA_W-1:0] prod;
  logic              prod_sat;

  fx_mul_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
    .a   (s1_q_q),
    .b   (s1_g_q),
    .y   (prod),
    .sat (prod_sat)
  );

  // in_ready looks through to out_ready so a draining output frees stage 1 in the same cycle.
  assign s2_load      = s1_valid_q && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || s2_load;
  assign accept       = bus.in_valid && bus.in_ready;
  assign oob          = bus.s_to_en > LAST_SEL;
  assign sel_idx      = oob ? '0 : bus.s_to_en;

  always_comb begin
    s1_valid_d   = accept || (s1_valid_q && !s2_load);
    s1_q_d       = s1_q_q;
    s1_g_d       = s1_g_q;
    out_valid_d  = s2_load || (out_valid_q && !bus.out_ready);
    gamma_maxq_d = gamma_maxq_q;
    sel_err_d    = sel_err_q || (accept && oob);
    sat_flag_d   = sat_flag_q || (s2_load && prod_sat);
    if (accept) begin
      s1_q_d = bus.max_q_bus[sel_idx*DATA_W +: DATA_W];
      s1_g_d = bus.gamma;
    end
    if (s2_load) gamma_maxq_d = prod;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q   <= 1'b0;
      s1_q_q       <= '0;
      s1_g_q       <= '0;
      out_valid_q  <= 1'b0;
      gamma_maxq_q <= '0;
      sel_err_q    <= 1'b0;
      sat_flag_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q_q       <= s1_q_d;
      s1_g_q       <= s1_g_d;
      out_valid_q  <= out_valid_d;
      gamma_maxq_q <= gamma_maxq_d;
      sel_err_q    <= sel_err_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.gamma_maxq = gamma_maxq_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.sat_flag   = sat_flag_q;
endmodule
